uart_tx_fifo_modul: RTL and testbench
=====================================

# uart_tx_fifo_modul

Buffered UART transmitter: accepts bytes from the filter datapath through a valid/ready push interface, queues them in a small FIFO and serializes each as an 8N1-style frame (start bit, D_BITS data bits LSB-first, SP_BITS stop bits) on `o_tx`. It is the transmit end of the host link and drives the FPGA-to-PC serial line. The FIFO absorbs filter output bursts, so `o_dvalid` pulses are not lost while a frame is on the wire.

## Interface
- `clk_speed`, 100_000000, system clock frequency in Hz
- `baudrate`, 921600, line rate in bit/s
- `D_BITS`, 8, data bits per frame
- `SP_BITS`, 1, stop bits per frame (1 or 2)
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥2

- `i_clk`  input  1  system clock; all logic is on the rising edge
- `reset`  input  1  reset, asynchronous, active-low
- `tx_data`  input  D_BITS  byte to queue
- `i_tx_enable`  input  1  push strobe; the byte is accepted when `o_tx_rdy`=1 in the same cycle
- `o_tx_rdy`  output  1  FIFO not full
- `o_tx`  output  1  serial line; idle high
- `o_tx_done`  output  1  one-cycle pulse on the last cycle of each frame's final stop bit
- `o_tx_busy`  output  1  serializer not in IDLE
- `o_fifo_count`  output  $clog2(FIFO_DEPTH)+1  number of queued bytes, excluding the byte being shifted

## Operation
- `CLKS_PER_BIT` = `clk_speed`/`baudrate`, integer division. Defaults give 108. Every bit occupies exactly `CLKS_PER_BIT` cycles.
- Frame length = (1+D_BITS+SP_BITS)×`CLKS_PER_BIT` cycles.
- FIFO:
  - A push occurs when `i_tx_enable` && `o_tx_rdy`.
  - A push while full is dropped silently. Count and pointers do not change.
  - `o_tx_rdy` = (count < FIFO_DEPTH), decoded from the registered count.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle leave the count unchanged.
  - Bytes are transmitted in push order.
- Serializer FSM, states IDLE, START, DATA, STOP. A baud counter and a bit index are cleared on each state entry.
  - IDLE: `o_tx`=1. If count>0, pop into the shift register and go to START.
  - START: `o_tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `o_tx`=shift[0] for each bit, shifting right after every bit. After D_BITS bits, go to STOP.
  - STOP: `o_tx`=1 for SP_BITS×CLKS_PER_BIT cycles. On the last cycle, pulse `o_tx_done`, then:
    - if count>0, pop in that same cycle and go directly to START (no idle gap);
    - else go to IDLE.
- `o_tx_busy` = (state != IDLE).
- `o_tx` is driven from a register (glitch-free).
- Reset, including mid-frame:
  - all state clears immediately;
  - FIFO is flushed;
  - the partial frame is abandoned and is not resumed.
- Output values while `reset`=0: `o_tx`=1, `o_tx_rdy`=1, `o_tx_done`=0, `o_tx_busy`=0, `o_fifo_count`=0.

## Timing
- Push at edge k into an empty FIFO while IDLE:
  - count=1 after edge k;
  - pop at edge k+1;
  - `o_tx` falls after edge k+1 (start bit begins 1 cycle after count becomes 1);
  - `o_fifo_count` returns to 0 after edge k+1.
- `o_tx_done` is high for exactly one cycle: the last cycle of the frame.
- Back-to-back frames: the next start bit begins on the cycle immediately after the `o_tx_done` cycle.
- Full FIFO with a pop on the STOP last cycle:
  - `o_tx_rdy` is still 0 in that cycle, so a push there is dropped;
  - `o_tx_rdy` rises in the following cycle.
- `o_tx_rdy` responds 1 cycle after the count changes. There is no combinational path from `i_tx_enable` to `o_tx_rdy`.

## Test plan
- Reset:
  - hold `reset`=0 → `o_tx`=1, `o_tx_rdy`=1, count 0, `o_tx_busy`=0;
  - deassert, queue 0x3C, assert reset 3 bits into the frame → `o_tx`=1 asynchronously and count=0;
  - after release, the line stays idle with no residual frame.
- Single byte 0xA5, defaults:
  - `o_tx` low starting 1 cycle after the push edge, for 108 cycles;
  - then data 1,0,1,0,0,1,0,1, each 108 cycles, then stop high for 108 cycles;
  - `o_tx_done` pulses once, at the frame's 1080th cycle.
- Back-to-back 0x00, 0xFF, 0x55 pushed on consecutive cycles:
  - 3 frames with no idle cycle between a stop bit and the next start bit;
  - `o_tx_done` pulses spaced exactly 1080 cycles;
  - `o_tx_busy` stays 1 throughout.
- Overflow: 18 pushes on consecutive cycles from idle, 0x01..0x12:
  - 0x01 is popped, then 16 bytes fill the FIFO;
  - `o_tx_rdy`=0 from the 18th cycle, and 0x12 is dropped;
  - 17 frames emerge, 0x01..0x11, in order;
  - `o_tx_rdy` returns to 1 the cycle after the first `o_tx_done`.
- Parameter variant: `clk_speed`=16, `baudrate`=1, `D_BITS`=7, `SP_BITS`=2, byte 0x41 → 16-cycle bits, data 1,0,0,0,0,0,1, a 32-cycle stop, frame length 160 cycles.
- Push during a frame: push 0x7E while 0x81 is in DATA → `o_fifo_count`=1 until the STOP last cycle of 0x81, then 0, and 0x7E starts immediately after.

Source files
------------

// File: rtl/uart_tx_fifo_modul.sv
// Buffered UART transmitter: a small FIFO feeding a start/data/stop serializer.
// The next queued byte is popped on the final stop cycle, so back-to-back frames leave no idle gap.
module uart_tx_fifo_modul #(
    parameter int clk_speed  = 100_000000,
    parameter int baudrate   = 921600,
    parameter int D_BITS     = 8,
    parameter int SP_BITS    = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          reset,
    input  logic [D_BITS-1:0]             tx_data,
    input  logic                          i_tx_enable,
    output logic                          o_tx_rdy,
    output logic                          o_tx,
    output logic                          o_tx_done,
    output logic                          o_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int CLKS_PER_BIT = clk_speed / baudrate;
    localparam int STOP_CLKS    = SP_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(STOP_CLKS + 1);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int IDX_W        = $clog2(D_BITS + 1);

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_CLKS - 1);
    localparam logic [CNT_W-1:0] STOP_PRE   = CNT_W'((STOP_CLKS >= 2) ? STOP_CLKS - 2 : 0);
    localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(D_BITS - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = FIFO_DEPTH[PTR_W:0];

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     baud_cnt_reg;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic [D_BITS-1:0]    shift_reg;
    logic [D_BITS-1:0]    shift_next;
    logic                 tx_reg;
    logic                 done_reg;

    logic [D_BITS-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [PTR_W:0]       count_reg;

    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 stop_end;

    // Ready decodes only the registered count, so there is no path from i_tx_enable.
    assign o_tx_rdy   = (count_reg < FULL_COUNT);
    assign push       = i_tx_enable && o_tx_rdy;
    assign bit_end    = (baud_cnt_reg == BIT_LAST);
    assign stop_end   = (baud_cnt_reg == STOP_LAST);
    assign pop        = (count_reg != '0) &&
                        ((state_reg == IDLE) || ((state_reg == STOP) && stop_end));
    assign shift_next = shift_reg >> 1;

    assign o_tx         = tx_reg;
    assign o_tx_done    = done_reg;
    assign o_tx_busy    = (state_reg != IDLE);
    assign o_fifo_count = count_reg;

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr_reg] <= tx_data;
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (pop) begin
                        shift_reg    <= mem[rd_ptr_reg];
                        state_reg    <= START;
                        tx_reg       <= 1'b0;
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_reg    <= DATA;
                        tx_reg       <= shift_reg[0];
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == DATA_LAST) begin
                            state_reg   <= STOP;
                            tx_reg      <= 1'b1;
                            bit_idx_reg <= '0;
                            done_reg    <= (STOP_CLKS == 1);
                        end else begin
                            shift_reg   <= shift_next;
                            tx_reg      <= shift_next[0];
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (stop_end) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        if (pop) begin
                            shift_reg <= mem[rd_ptr_reg];
                            state_reg <= START;
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                            tx_reg    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                        // Registered pulse: arm one cycle early so it lands on the final stop cycle.
                        if ((STOP_CLKS >= 2) && (baud_cnt_reg == STOP_PRE))
                            done_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_modul.sv
// Directed bench for uart_tx_fifo_modul: default 921600-baud instance plus a 7-bit, 2-stop variant.
module tb_uart_tx_fifo_modul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] data0;
    logic       en0;
    logic       rdy0, tx0, done0, busy0;
    logic [4:0] cnt0;
    logic [6:0] data1;
    logic       en1;
    logic       rdy1, tx1, done1, busy1;
    logic [4:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_fifo_modul dut0 (
        .i_clk(clk), .reset(rst_n), .tx_data(data0), .i_tx_enable(en0),
        .o_tx_rdy(rdy0), .o_tx(tx0), .o_tx_done(done0), .o_tx_busy(busy0),
        .o_fifo_count(cnt0)
    );

    uart_tx_fifo_modul #(
        .clk_speed(16), .baudrate(1), .D_BITS(7), .SP_BITS(2), .FIFO_DEPTH(16)
    ) dut1 (
        .i_clk(clk), .reset(rst_n), .tx_data(data1), .i_tx_enable(en1),
        .o_tx_rdy(rdy1), .o_tx(tx1), .o_tx_done(done1), .o_tx_busy(busy1),
        .o_fifo_count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input int sel, input logic [7:0] d);
        @(negedge clk);
        if (sel == 0) begin data0 = d; en0 = 1'b1; end
        else begin data1 = d[6:0]; en1 = 1'b1; end
        @(negedge clk);
        en0 = 1'b0;
        en1 = 1'b0;
    endtask

    // Called just before the negedge of frame cycle 1 (the first start-bit cycle).
    task automatic frame_check(input int sel, input logic [7:0] data, input int cpb,
                               input int nd, input int nsp, input string tag,
                               output logic rdy_c1, output logic rdy_last,
                               output logic [4:0] cnt_c1, output logic [4:0] cnt_last);
        int frame_len;
        int done_cnt;
        int done_at;
        int busy_low;
        int b;
        logic tx_s, done_s, busy_s, rdy_s, exp_bit;
        logic [4:0] cnt_s;
        frame_len = cpb * (1 + nd + nsp);
        done_cnt = 0;
        done_at = 0;
        busy_low = 0;
        rdy_c1 = 1'b0;
        rdy_last = 1'b0;
        cnt_c1 = '0;
        cnt_last = '0;
        for (int c = 1; c <= frame_len; c++) begin
            @(negedge clk);
            tx_s   = (sel != 0) ? tx1   : tx0;
            done_s = (sel != 0) ? done1 : done0;
            busy_s = (sel != 0) ? busy1 : busy0;
            rdy_s  = (sel != 0) ? rdy1  : rdy0;
            cnt_s  = (sel != 0) ? cnt1  : cnt0;
            if (c == 1) begin
                rdy_c1 = rdy_s;
                cnt_c1 = cnt_s;
                check($sformatf("%s_start_edge", tag), tx_s, 1'b0);
            end
            if (c == frame_len) begin
                rdy_last = rdy_s;
                cnt_last = cnt_s;
            end
            if (done_s) begin done_cnt++; done_at = c; end
            if (!busy_s) busy_low++;
            if ((c - 1) % cpb == cpb / 2) begin
                b = (c - 1) / cpb;
                if (b == 0)       exp_bit = 1'b0;
                else if (b <= nd) exp_bit = data[b-1];
                else              exp_bit = 1'b1;
                check($sformatf("%s_bit%0d", tag, b), tx_s, exp_bit);
            end
        end
        check($sformatf("%s_done_count", tag), done_cnt, 1);
        check($sformatf("%s_done_cycle", tag), done_at, frame_len);
        check($sformatf("%s_busy_low_cycles", tag), busy_low, 0);
        $display("frame %s: data 0x%0h, %0d cycles", tag, data, frame_len);
    endtask

    initial begin
        logic r1, rl;
        logic [4:0] c1, cl;
        int idle_bad;

        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; data0 = '0; data1 = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx0, 1'b1);
        check("rst_rdy", rdy0, 1'b1);
        check("rst_cnt", cnt0, 0);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_var_tx", tx1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a frame with one more byte still queued
        @(negedge clk); data0 = 8'h3C; en0 = 1'b1;
        @(negedge clk); data0 = 8'h99;
        @(negedge clk); en0 = 1'b0;
        repeat (270) @(negedge clk);
        check("rstmid_tx_before", tx0, 1'b0);
        check("rstmid_busy_before", busy0, 1'b1);
        check("rstmid_cnt_before", cnt0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_tx_async", tx0, 1'b1);
        check("rstmid_cnt_async", cnt0, 0);
        check("rstmid_busy_async", busy0, 1'b0);
        check("rstmid_rdy_async", rdy0, 1'b1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) idle_bad++;
        end
        check("rstmid_idle_after", idle_bad, 0);
        check("rstmid_cnt_after", cnt0, 0);
        $display("reset mid-frame: line idle after release");

        // Single byte
        push_byte(0, 8'hA5);
        check("single_cnt_after_push", cnt0, 1);
        check("single_tx_idle_after_push", tx0, 1'b1);
        check("single_busy_after_push", busy0, 1'b0);
        frame_check(0, 8'hA5, 108, 8, 1, "single", r1, rl, c1, cl);
        check("single_cnt_c1", c1, 0);
        @(negedge clk);
        check("single_busy_end", busy0, 1'b0);
        check("single_tx_end", tx0, 1'b1);

        // Back-to-back frames
        @(negedge clk); data0 = 8'h00; en0 = 1'b1;
        fork
            begin
                @(negedge clk); data0 = 8'hFF;
                @(negedge clk); data0 = 8'h55;
                @(negedge clk); en0 = 1'b0;
            end
            begin
                logic ra, rb;
                logic [4:0] ca, cb;
                @(negedge clk);
                frame_check(0, 8'h00, 108, 8, 1, "b2b0", ra, rb, ca, cb);
                check("b2b0_cnt_c1", ca, 1);
                check("b2b0_cnt_last", cb, 2);
                frame_check(0, 8'hFF, 108, 8, 1, "b2b1", ra, rb, ca, cb);
                check("b2b1_cnt_last", cb, 1);
                frame_check(0, 8'h55, 108, 8, 1, "b2b2", ra, rb, ca, cb);
                check("b2b2_cnt_last", cb, 0);
            end
        join
        @(negedge clk);
        check("b2b_busy_end", busy0, 1'b0);

        // Overflow: 18 consecutive pushes, 0x12 must be dropped
        @(negedge clk); data0 = 8'h01; en0 = 1'b1;
        fork
            begin
                for (int i = 1; i <= 17; i++) begin
                    @(negedge clk);
                    check($sformatf("ovf_rdy_%0d", i), rdy0, (i < 17) ? 1 : 0);
                    data0 = 8'(i + 1);
                end
                @(negedge clk); en0 = 1'b0;
            end
            begin
                logic ra, rb;
                logic [4:0] ca, cb;
                @(negedge clk);
                for (int f = 0; f < 17; f++) begin
                    frame_check(0, 8'(f + 1), 108, 8, 1, $sformatf("ovf%0d", f), ra, rb, ca, cb);
                    if (f == 0) begin
                        check("ovf_cnt_at_done", cb, 16);
                        check("ovf_rdy_at_done", rb, 1'b0);
                    end
                    if (f == 1) check("ovf_rdy_after_done", ra, 1'b1);
                end
            end
        join
        @(negedge clk);
        check("ovf_busy_end", busy0, 1'b0);
        check("ovf_tx_end", tx0, 1'b1);
        check("ovf_cnt_end", cnt0, 0);

        // Push while a frame is in its data bits
        push_byte(0, 8'h81);
        fork
            begin
                logic ra, rb;
                logic [4:0] ca, cb;
                frame_check(0, 8'h81, 108, 8, 1, "pdf0", ra, rb, ca, cb);
                check("pdf0_cnt_last", cb, 1);
                frame_check(0, 8'h7E, 108, 8, 1, "pdf1", ra, rb, ca, cb);
                check("pdf1_cnt_c1", ca, 0);
            end
            begin
                repeat (220) @(negedge clk);
                data0 = 8'h7E; en0 = 1'b1;
                @(negedge clk);
                en0 = 1'b0;
                check("pdf_cnt_queued", cnt0, 1);
                check("pdf_busy_queued", busy0, 1'b1);
            end
        join

        // Parameter variant: 16-cycle bits, 7 data bits, 2 stop bits
        push_byte(1, 8'h41);
        check("var_cnt_after_push", cnt1, 1);
        frame_check(1, 8'h41, 16, 7, 2, "var", r1, rl, c1, cl);
        @(negedge clk);
        check("var_busy_end", busy1, 1'b0);
        check("var_tx_end", tx1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
